// File: rtl/ram2_pipe.sv
// Dual-port waveform RAM with a post-reset zero-fill sequencer, a selectable
// 1- or 2-cycle registered read path, read-during-write control and a read-valid strobe.
module ram2_pipe #(
    parameter int ADDRESS_WIDTH  = 9,
    parameter int DATA_WIDTH     = 8,
    parameter int RD_LATENCY     = 1,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr,
    input  logic [ADDRESS_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]    din,
    input  logic                     rd,
    input  logic [ADDRESS_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]    dout,
    output logic                     dout_valid,
    output logic                     ready
);
    localparam int DEPTH = 2 ** ADDRESS_WIDTH;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t                   state, state_nx;
    logic [ADDRESS_WIDTH-1:0] clr_addr, clr_addr_nx;
    logic [DATA_WIDTH-1:0]    ram [DEPTH];
    logic                     we;
    logic [ADDRESS_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0]    wdata;
    logic                     rd_acc;
    logic [DATA_WIDTH-1:0]    rdata;
    logic [DATA_WIDTH-1:0]    data_p0;
    logic                     vld_p0;

    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
        $error("ram2_pipe: RD_LATENCY must be 1 or 2");
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
            clr_addr <= '0;
        end else begin
            state    <= state_nx;
            clr_addr <= clr_addr_nx;
        end
    end

    // Port arbitration: the clear sequencer owns the write port until the
    // last word is zeroed; user traffic is dropped while it runs.
    always_comb begin
        state_nx    = state;
        clr_addr_nx = clr_addr;
        we          = 1'b0;
        waddr       = wr_addr;
        wdata       = din;
        rd_acc      = 1'b0;
        case (state)
            CLEAR: begin
                we          = ~rst;
                waddr       = clr_addr;
                wdata       = '0;
                clr_addr_nx = clr_addr + 1'b1;
                if (clr_addr == ADDRESS_WIDTH'(DEPTH - 1))
                    state_nx = RUN;
            end
            RUN: begin
                we     = wr & ~rst;
                rd_acc = rd & ~rst;
            end
            default: state_nx = RUN;
        endcase
    end

    assign ready = (state == RUN);

    always_ff @(posedge clk) begin
        if (we)
            ram[waddr] <= wdata;
    end

    // New-data mode bypasses din when both ports hit the same word.
    assign rdata = (RDW_MODE != 0 && wr && wr_addr == rd_addr) ? din : ram[rd_addr];

    // Stage p0: array read register
    always_ff @(posedge clk) begin
        if (rst) begin
            data_p0 <= '0;
            vld_p0  <= 1'b0;
        end else begin
            vld_p0 <= rd_acc;
            if (rd_acc)
                data_p0 <= rdata;
        end
    end

    if (RD_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] data_p1;
        logic                  vld_p1;

        // Stage p1: optional output register
        always_ff @(posedge clk) begin
            if (rst) begin
                data_p1 <= '0;
                vld_p1  <= 1'b0;
            end else begin
                vld_p1 <= vld_p0;
                if (vld_p0)
                    data_p1 <= data_p0;
            end
        end

        assign dout       = data_p1;
        assign dout_valid = vld_p1;
    end else begin : g_lat1
        assign dout       = data_p0;
        assign dout_valid = vld_p0;
    end
endmodule
